tick_scheduler: RTL and testbench

TICK_SCHEDULER -- requirements
Module: tick_scheduler

---
 rtl/tick_sched_pkg.sv | 24 ++
 rtl/tick_gen.sv | 55 +++++
 rtl/tick_scheduler.sv | 164 ++++++++++++++++
 tb/tb_tick_scheduler.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tick_sched_pkg
// Description : Shared types and default constants for the tick scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package tick_sched_pkg;

    // Scheduler control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Default clock frequency in Hz
    localparam int c_CLK_FREQ = 12_000_000;
    // Default scheduler time-base rate in Hz
    localparam int c_TICK_HZ  = 1000;
    // Default width of a requester delay field
    localparam int c_CNT_W    = 16;

endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen
// Description : Prescaler emitting a registered one-cycle tick every PERIOD
//               enabled cycles; the first tick lands PERIOD cycles after the
//               cycle in which clear was last asserted.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int PERIOD = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int c_CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(PERIOD - 1);
    localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

    // A period below one clock cannot be represented; refuse to elaborate.
    if (PERIOD < 1) begin : g_period_check
        $error("tick_gen: PERIOD must be at least 1");
    end

    logic [c_CNT_W-1:0] r_count;
    logic               r_tick;

    // Count 0..PERIOD-1 while enabled and register a tick on the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_tick  <= 1'b0;
        end else if (clear) begin
            r_count <= '0;
            r_tick  <= 1'b0;
        end else if (enable) begin
            if (r_count == c_LAST) begin
                r_count <= '0;
                r_tick  <= 1'b1;
            end else begin
                r_count <= r_count + c_ONE;
                r_tick  <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tick_scheduler
// Description : Round-robin owner of one shared tick timer. An idle requester
//               is granted the timer, waits delay ticks, and receives a
//               one-cycle done pulse; dropping req while counting cancels.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int CLK_FREQ = c_CLK_FREQ,
    parameter int TICK_HZ  = c_TICK_HZ,
    parameter int N_REQ    = 4,
    parameter int CNT_W    = c_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] delay,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic                   busy
);

    localparam int c_PERIOD = CLK_FREQ / TICK_HZ;
    localparam int c_LW_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [c_LW_W-1:0] c_LAST_IDX = c_LW_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0]  c_ONE      = CNT_W'(1);

    state_t              r_state,     w_state_nxt;
    logic [N_REQ-1:0]    r_grant,     w_grant_nxt;
    logic [N_REQ-1:0]    r_done,      w_done_nxt;
    logic                r_busy,      w_busy_nxt;
    logic [CNT_W-1:0]    r_remaining, w_remaining_nxt;
    logic [c_LW_W-1:0]   r_last,      w_last_nxt;

    logic [c_LW_W-1:0]   w_start;
    logic [c_LW_W-1:0]   w_winner;
    logic [c_LW_W-1:0]   w_hi_idx;
    logic [c_LW_W-1:0]   w_lo_idx;
    logic                w_hi_hit;
    logic [CNT_W-1:0]    w_sel_delay;
    logic                w_owner_req;
    logic                w_tick;
    logic                w_tick_clear;
    logic                w_tick_en;

    // The prescaler restarts from zero whenever no job is counting.
    assign w_tick_clear = (r_state != COUNT);
    assign w_tick_en    = (r_state == COUNT);

    tick_gen #(
        .PERIOD (c_PERIOD)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (w_tick_clear),
        .enable (w_tick_en),
        .tick   (w_tick)
    );

    assign w_start     = (r_last == c_LAST_IDX) ? '0 : r_last + c_LW_W'(1);
    assign w_owner_req = |(req & r_grant);

    // Round-robin pick: lowest requester at or above start, else lowest overall.
    always_comb begin
        w_hi_idx = '0;
        w_lo_idx = '0;
        w_hi_hit = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_lo_idx = c_LW_W'(i);
                if (i >= int'(w_start)) begin
                    w_hi_idx = c_LW_W'(i);
                    w_hi_hit = 1'b1;
                end
            end
        end
        w_winner = w_hi_hit ? w_hi_idx : w_lo_idx;
    end

    // Select the delay field belonging to the arbitration winner.
    always_comb begin
        w_sel_delay = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_winner == c_LW_W'(i)) begin
                w_sel_delay = delay[i*CNT_W +: CNT_W];
            end
        end
    end

    // Next-state and next-output decode; cancel outranks the final tick.
    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_done_nxt      = '0;
        w_remaining_nxt = r_remaining;
        w_last_nxt      = r_last;
        unique case (r_state)
            IDLE: begin
                if (|req) begin
                    w_state_nxt           = COUNT;
                    w_grant_nxt           = '0;
                    w_grant_nxt[w_winner] = 1'b1;
                    w_remaining_nxt       = w_sel_delay;
                    w_last_nxt            = w_winner;
                end
            end
            COUNT: begin
                if (!w_owner_req) begin
                    w_state_nxt     = IDLE;
                    w_grant_nxt     = '0;
                    w_remaining_nxt = '0;
                end else if (r_remaining == '0) begin
                    w_state_nxt = DONE;
                    w_done_nxt  = r_grant;
                end else if (w_tick) begin
                    w_remaining_nxt = r_remaining - c_ONE;
                    if (r_remaining == c_ONE) begin
                        w_state_nxt = DONE;
                        w_done_nxt  = r_grant;
                    end
                end
            end
            DONE: begin
                w_state_nxt     = IDLE;
                w_grant_nxt     = '0;
                w_remaining_nxt = '0;
            end
            default: begin
                w_state_nxt     = IDLE;
                w_grant_nxt     = '0;
                w_remaining_nxt = '0;
            end
        endcase
        w_busy_nxt = (w_state_nxt != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_done      <= '0;
            r_busy      <= 1'b0;
            r_remaining <= '0;
            r_last      <= c_LAST_IDX;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_done      <= w_done_nxt;
            r_busy      <= w_busy_nxt;
            r_remaining <= w_remaining_nxt;
            r_last      <= w_last_nxt;
        end
    end

    assign grant = r_grant;
    assign done  = r_done;
    assign busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_tick_scheduler
// Description : Self-checking bench for tick_scheduler with P = 10, N_REQ = 4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tick_scheduler;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req   = '0;
    logic [N*W-1:0] delay = '0;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic           busy;

    typedef struct {
        logic [N-1:0]   req;
        logic [N*W-1:0] dly;
        logic [N-1:0]   exp_grant;
        int             exp_lat;
    } vec_t;

    typedef struct {
        logic [N-1:0] vec;
        int           lat;
    } done_exp_t;

    logic [N-1:0] grant_q[$];
    done_exp_t    done_q[$];

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int grant_cyc = 0;
    int n_done    = 0;
    logic [N-1:0] prev_grant = '0;

    vec_t vecs[7];

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    tick_scheduler #(
        .CLK_FREQ (100),
        .TICK_HZ  (10),
        .N_REQ    (N),
        .CNT_W    (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .delay (delay),
        .grant (grant),
        .done  (done),
        .busy  (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N*W-1:0] mk_dly(input int d0, input int d1, input int d2, input int d3);
        return {W'(d3), W'(d2), W'(d1), W'(d0)};
    endfunction

    // Scoreboard: pop expectations when a grant rises or a done pulse appears.
    always @(negedge clk) begin : mon
        logic [N-1:0] eg;
        done_exp_t    ed;
        check("grant_onehot", 64'($countones(grant) <= 1), 64'd1);
        if (grant != '0 && prev_grant == '0) begin
            if (grant_q.size() == 0) begin
                check("grant_unexpected", 64'(grant), 64'd0);
            end else begin
                eg = grant_q.pop_front();
                check("grant_order", 64'(grant), 64'(eg));
            end
            grant_cyc = cyc;
        end
        if (done != '0) begin
            n_done++;
            if (done_q.size() == 0) begin
                check("done_unexpected", 64'(done), 64'd0);
            end else begin
                ed = done_q.pop_front();
                check("done_vec", 64'(done), 64'(ed.vec));
                check("done_grant", 64'(grant), 64'(ed.vec));
                check("done_latency", 64'(cyc - grant_cyc), 64'(ed.lat));
            end
        end
        prev_grant = grant;
    end

    task automatic wait_done(input int max, output int busy_cnt);
        bit ok;
        ok = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done != '0) begin
                ok = 1'b1;
                break;
            end
        end
        check("done_timeout", 64'(ok), 64'd1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_grant"}, 64'(grant), 64'd0);
        check({tag, "_busy"},  64'(busy),  64'd0);
        check({tag, "_done"},  64'(done),  64'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int bc;
        @(negedge clk);
        grant_q.push_back(v.exp_grant);
        done_q.push_back(done_exp_t'{v.exp_grant, v.exp_lat});
        req   = v.req;
        delay = v.dly;
        @(negedge clk);
        check("grant_1cyc", 64'(grant), 64'(v.exp_grant));
        wait_done(v.exp_lat + 20, bc);
        check("busy_cycles", 64'(bc + 1), 64'(v.exp_lat + 1));
        req = '0;
        @(negedge clk);
        check_idle("after_done");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bc;
        int nd;
        vecs[0] = '{4'b0001, mk_dly(3, 0, 0, 0), 4'b0001, 31};
        vecs[1] = '{4'b0100, mk_dly(0, 0, 0, 0), 4'b0100, 1};
        vecs[2] = '{4'b1000, mk_dly(0, 0, 0, 2), 4'b1000, 21};
        vecs[3] = '{4'b0011, mk_dly(1, 2, 0, 0), 4'b0001, 11};
        vecs[4] = '{4'b0011, mk_dly(1, 2, 0, 0), 4'b0010, 21};
        vecs[5] = '{4'b1001, mk_dly(1, 0, 0, 0), 4'b1000, 1};
        vecs[6] = '{4'b0110, mk_dly(0, 1, 3, 0), 4'b0010, 11};

        repeat (2) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Fairness: all four held, priority restarts at 0 after reset.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_idle("reset2");
        rst_n = 1'b1;
        grant_q.push_back(4'b0001);
        grant_q.push_back(4'b0010);
        grant_q.push_back(4'b0100);
        grant_q.push_back(4'b1000);
        grant_q.push_back(4'b0001);
        done_q.push_back(done_exp_t'{4'b0001, 11});
        done_q.push_back(done_exp_t'{4'b0010, 11});
        done_q.push_back(done_exp_t'{4'b0100, 11});
        done_q.push_back(done_exp_t'{4'b1000, 11});
        done_q.push_back(done_exp_t'{4'b0001, 11});
        delay = mk_dly(1, 1, 1, 1);
        req   = 4'b1111;
        for (int k = 0; k < 5; k++) wait_done(30, bc);
        req = '0;
        @(negedge clk);
        check_idle("fair_end");
        check("fair_queue_empty", 64'(grant_q.size() + done_q.size()), 64'd0);

        // Cancel mid-count: owner 1 drops req 25 cycles after its grant.
        @(negedge clk);
        grant_q.push_back(4'b0010);
        req   = 4'b0010;
        delay = mk_dly(0, 5, 0, 0);
        @(negedge clk);
        check("cancel_grant", 64'(grant), 64'b0010);
        nd = n_done;
        repeat (25) @(negedge clk);
        req = '0;
        @(negedge clk);
        check_idle("cancel");
        repeat (5) @(negedge clk);
        check("cancel_no_done", 64'(n_done), 64'(nd));
        run_vec('{4'b0111, mk_dly(0, 0, 0, 0), 4'b0100, 1});

        // Reset 15 cycles into a delay-4 job, then immediate re-arbitration.
        @(negedge clk);
        grant_q.push_back(4'b0001);
        req   = 4'b0001;
        delay = mk_dly(4, 0, 0, 0);
        @(negedge clk);
        check("rst_job_grant", 64'(grant), 64'b0001);
        repeat (15) @(negedge clk);
        nd = n_done;
        rst_n = 1'b0;
        #1;
        check_idle("async_reset");
        grant_q.push_back(4'b0001);
        done_q.push_back(done_exp_t'{4'b0001, 41});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("grant_after_release", 64'(grant), 64'b0001);
        check("rst_no_done", 64'(n_done), 64'(nd));
        wait_done(60, bc);
        req = '0;
        @(negedge clk);
        check_idle("rst_job_end");

        // Cancel on the same cycle as the final tick: cancel wins.
        @(negedge clk);
        grant_q.push_back(4'b0001);
        req   = 4'b0001;
        delay = mk_dly(1, 0, 0, 0);
        @(negedge clk);
        check("tickcancel_grant", 64'(grant), 64'b0001);
        nd = n_done;
        repeat (10) @(negedge clk);
        req = '0;
        @(negedge clk);
        check_idle("tickcancel");
        repeat (5) @(negedge clk);
        check("tickcancel_no_done", 64'(n_done), 64'(nd));
        check("final_queue_empty", 64'(grant_q.size() + done_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
